// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_pkg.sv
// Shared definitions for the presettable register bank: index width helper,
// slice addressing and the next-state selector used by each channel.
package gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_pkg;

    // Synchroniser flops idle at 1 so a freshly reset bank never sees a set.
    localparam logic SYNC_RST_VAL = 1'b1;

    typedef enum logic [1:0] {
        NXT_HOLD  = 2'd0,
        NXT_LOAD  = 2'd1,
        NXT_FORCE = 2'd2
    } nxt_sel_e;

    function automatic int calc_ch_w(input int channels);
        int w;
        if (channels > 1) begin
            w = $clog2(channels);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_sync.sv
// One-bit reset-to-1 synchroniser for an active-low set request, with a
// falling-edge detector that ignores levels already low at reset release.
module gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_sync
    import gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic setn_async,
    output logic setn_next,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_r;
    logic [SYNC_STAGES-1:0] live_r;
    logic                   ssetn_d_r;
    logic                   live_d_r;
    logic                   ssetn_s;

    // live_r tracks which stages hold a genuine post-reset sample, so the
    // reset-forced 1 can never be mistaken for a high-to-low transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r   <= {SYNC_STAGES{SYNC_RST_VAL}};
            live_r    <= {SYNC_STAGES{1'b0}};
            ssetn_d_r <= SYNC_RST_VAL;
            live_d_r  <= 1'b0;
        end else begin
            stage_r   <= {stage_r[SYNC_STAGES-2:0], setn_async};
            live_r    <= {live_r[SYNC_STAGES-2:0], 1'b1};
            ssetn_d_r <= stage_r[SYNC_STAGES-1];
            live_d_r  <= live_r[SYNC_STAGES-1];
        end
    end

    assign ssetn_s = stage_r[SYNC_STAGES-1];
    // Value entering the final stage: lets the channel register change on
    // the same edge that the synchronised output does.
    assign setn_next = stage_r[SYNC_STAGES-2];
    assign fall      = ssetn_d_r & live_d_r & ~ssetn_s;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latsnq_bank.sv
// Bank of CHANNELS presettable WIDTH-bit registers with synchronised force-set,
// sticky set flags and a one-cycle registered read port.
module gf180mcu_fd_sc_mcu9t5v0__latsnq_bank
    import gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CHANNELS    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
    parameter int               SYNC_STAGES = 2,
    parameter bit               CLR_ON_RD   = 1'b1,
    localparam int              CH_W        = calc_ch_w(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RN,
    input  logic [CHANNELS-1:0]       E,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       SETN,
    output logic [CHANNELS*WIDTH-1:0] Q,
    input  logic                      RD_REQ,
    input  logic [CH_W-1:0]           RD_CH,
    output logic                      RD_ACK,
    output logic [WIDTH-1:0]          RD_DATA,
    output logic                      RD_FLAG
);

    logic [CHANNELS*WIDTH-1:0] q_flat_s;
    logic [CHANNELS-1:0]       setn_next_s;
    logic [CHANNELS-1:0]       fall_s;
    logic [CHANNELS-1:0]       clr_s;
    logic [CHANNELS-1:0]       flag_r;
    logic                      rd_hit_s;
    logic [WIDTH-1:0]          rd_data_s;
    logic                      rd_flag_s;
    logic                      rd_ack_r;
    logic [WIDTH-1:0]          rd_data_r;
    logic                      rd_flag_r;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] q_r;
        nxt_sel_e         sel_s;

        gf180mcu_fd_sc_mcu9t5v0__latsnq_bank_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk        (CLK),
            .rst_n      (RN),
            .setn_async (SETN[c]),
            .setn_next  (setn_next_s[c]),
            .fall       (fall_s[c])
        );

        // Force-set outranks load; otherwise the channel holds.
        always_comb begin
            sel_s = NXT_HOLD;
            if (!setn_next_s[c]) begin
                sel_s = NXT_FORCE;
            end else if (E[c]) begin
                sel_s = NXT_LOAD;
            end else begin
                sel_s = NXT_HOLD;
            end
        end

        // Channel storage register.
        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                q_r <= RESET_VAL;
            end else begin
                case (sel_s)
                    NXT_FORCE: q_r <= {WIDTH{1'b1}};
                    NXT_LOAD:  q_r <= D[slice_lo(c, WIDTH) +: WIDTH];
                    NXT_HOLD:  q_r <= q_r;
                    default:   q_r <= q_r;
                endcase
            end
        end

        assign q_flat_s[slice_lo(c, WIDTH) +: WIDTH] = q_r;
        assign clr_s[c] = CLR_ON_RD & rd_hit_s & (RD_CH == CH_W'(c));
    end

    assign Q = q_flat_s;

    // Read mux: out-of-range indices answer with zeros and touch no flag.
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_data_s = {WIDTH{1'b0}};
        rd_flag_s = 1'b0;
        if (RD_REQ && (int'(RD_CH) < CHANNELS)) begin
            rd_hit_s  = 1'b1;
            rd_data_s = q_flat_s[int'(RD_CH)*WIDTH +: WIDTH];
            rd_flag_s = flag_r[RD_CH];
        end else begin
            rd_hit_s  = 1'b0;
            rd_data_s = {WIDTH{1'b0}};
            rd_flag_s = 1'b0;
        end
    end

    // Sticky flags: a new set event overrides a same-cycle read clear.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            flag_r <= {CHANNELS{1'b0}};
        end else begin
            flag_r <= fall_s | (flag_r & ~clr_s);
        end
    end

    // Read response register; data and flag hold while idle.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            rd_ack_r  <= 1'b0;
            rd_data_r <= {WIDTH{1'b0}};
            rd_flag_r <= 1'b0;
        end else begin
            rd_ack_r <= RD_REQ;
            if (RD_REQ) begin
                rd_data_r <= rd_data_s;
                rd_flag_r <= rd_flag_s;
            end else begin
                rd_data_r <= rd_data_r;
                rd_flag_r <= rd_flag_r;
            end
        end
    end

    assign RD_ACK  = rd_ack_r;
    assign RD_DATA = rd_data_r;
    assign RD_FLAG = rd_flag_r;

endmodule
